// File: rtl/mem_arb_pkg.sv
// Shared types and owner encodings for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_X = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch and execute.
// Operands are latched at acceptance; ACCESS lasts MEM_LAT cycles, then a one-cycle DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_done,
  output logic [DW-1:0] x_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CntLoad = CW'(MEM_LAT - 1);

  stateT         state, nextState;
  logic [CW-1:0] cnt;
  logic          owner, lastOwner, latWe;
  logic [AW-1:0] latAddr;
  logic [DW-1:0] latWdata;
  logic [DW-1:0] fRdataQ, xRdataQ;
  logic          accept, winner, firstCycle;

  // On a tie the port that was not served last wins.
  function automatic logic pickOwner(input logic fReq, input logic xReq, input logic last);
    if (fReq && xReq) return ~last;
    else if (xReq)    return OWN_X;
    else              return OWN_F;
  endfunction

  assign accept = (state == IDLE) && (f_req || x_req);
  assign winner = pickOwner(f_req, x_req, lastOwner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (f_req || x_req) nextState = ACCESS;
      ACCESS:  if (cnt == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      owner     <= OWN_F;
      lastOwner <= OWN_F;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      fRdataQ   <= '0;
      xRdataQ   <= '0;
    end else if (accept) begin
      cnt       <= CntLoad;
      owner     <= winner;
      lastOwner <= winner;
      latWe     <= (winner == OWN_X) && x_we;
      latAddr   <= (winner == OWN_X) ? x_addr : f_addr;
      latWdata  <= (winner == OWN_X) ? x_wdata : '0;
    end else if (state == ACCESS) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      // Read data is valid on the final ACCESS cycle only.
      if (cnt == '0 && !latWe) begin
        if (owner == OWN_X) xRdataQ <= mem_rdata;
        else                fRdataQ <= mem_rdata;
      end
    end
  end

  always_comb begin
    firstCycle = (state == ACCESS) && (cnt == CntLoad);
    f_gnt      = firstCycle && (owner == OWN_F);
    x_gnt      = firstCycle && (owner == OWN_X);
    f_done     = (state == DONE) && (owner == OWN_F);
    x_done     = (state == DONE) && (owner == OWN_X);
    mem_addr   = (state == ACCESS) ? latAddr : '0;
    mem_wdata  = (state == ACCESS && latWe) ? latWdata : '0;
    mem_we     = firstCycle && latWe;
    mem_re     = (state == ACCESS) && !latWe;
    busy       = (state != IDLE);
    f_rdata    = fRdataQ;
    x_rdata    = xRdataQ;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard; a second instance covers MEM_LAT=1.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        owner;
    logic        isWrite;
    logic [31:0] data;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, x_req, x_we;
  logic [31:0] f_addr, x_addr, x_wdata;
  logic        f_gnt, f_done, x_gnt, x_done, mem_we, mem_re, busy;
  logic [31:0] f_rdata, x_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        f1_req;
  logic [31:0] f1_addr;
  logic        f1_gnt, f1_done, x1_gnt, x1_done, mem1_we, mem1_re, busy1;
  logic [31:0] f1_rdata, x1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

  expT         sbq[$];
  int          nVec = 0, nErr = 0;
  int          reCnt = 0, weCount = 0, fGntCnt = 0;
  logic [31:0] weAddr, weData;

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  // Memory answers with good data only on the second read cycle.
  always @(posedge clk) reCnt <= mem_re ? reCnt + 1 : 0;
  assign mem_rdata  = (mem_re && reCnt == 1) ? memModel(mem_addr) : 32'hBAD0_BAD0;
  assign mem1_rdata = mem1_re ? memModel(mem1_addr) : 32'hBAD0_BAD0;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_done(x_done), .x_rdata(x_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(f1_req), .f_addr(f1_addr), .f_gnt(f1_gnt), .f_done(f1_done), .f_rdata(f1_rdata),
    .x_req(1'b0), .x_we(1'b0), .x_addr(32'h0), .x_wdata(32'h0),
    .x_gnt(x1_gnt), .x_done(x1_done), .x_rdata(x1_rdata),
    .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_we(mem1_we), .mem_re(mem1_re),
    .mem_rdata(mem1_rdata), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (f_gnt) fGntCnt++;
      if (f_gnt || x_gnt) check("gnt_excl", {31'b0, f_gnt & x_gnt}, 32'h0);
      if (!busy) check("mem_idle", {31'b0, mem_we | mem_re | (|mem_addr) | (|mem_wdata)}, 32'h0);
      if (mem_we) begin
        weCount++;
        weAddr = mem_addr;
        weData = mem_wdata;
      end
      if (f_done || x_done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", {30'b0, f_done, x_done}, 32'h0);
        end else begin
          expT e;
          e = sbq.pop_front();
          check("done_excl", {31'b0, f_done & x_done}, 32'h0);
          check("done_owner", {31'b0, x_done}, {31'b0, e.owner});
          if (!e.isWrite) check("done_rdata", x_done ? x_rdata : f_rdata, e.data);
        end
      end
    end
  end

  task automatic runTxn(input logic own, input logic we, input logic [31:0] addr,
                        input logic [31:0] data);
    logic got;
    expT  e;
    e.owner = own;
    e.isWrite = we;
    e.data = memModel(addr);
    sbq.push_back(e);
    if (own == OWN_X) begin
      x_req = 1'b1; x_we = we; x_addr = addr; x_wdata = data;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = (own == OWN_X) ? x_gnt : f_gnt;
    end
    check("gnt_seen", {31'b0, got}, 32'h1);
    // Requester is free to move on once granted; scramble to expose unlatched operands.
    x_req = 1'b0; f_req = 1'b0; x_addr = ~addr; f_addr = ~addr; x_wdata = ~data; x_we = ~we;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) step();
    check("drain", sbq.size(), 32'h0);
    step();
    step();
  endtask

  initial begin
    logic [31:0] prevX;
    int          nG;
    logic        gntOwn[4];
    int          gntCyc[4];
    expT         e;

    rst = 1'b1;
    f_req = 0; x_req = 0; x_we = 0; f_addr = 0; x_addr = 0; x_wdata = 0;
    f1_req = 0; f1_addr = 0;
    step();
    check("rst_ctl", {25'b0, busy, f_gnt, f_done, x_gnt, x_done, mem_we, mem_re}, 32'h0);
    check("rst_f_rdata", f_rdata, 32'h0);
    check("rst_x_rdata", x_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    step();

    // Tie held by both ports: execute wins first after reset, then strict alternation.
    f_addr = 32'h100; x_addr = 32'h200; x_we = 0;
    for (int k = 0; k < 4; k++) begin
      e.owner = (k % 2 == 0) ? OWN_X : OWN_F;
      e.isWrite = 1'b0;
      e.data = memModel((k % 2 == 0) ? 32'h200 : 32'h100);
      sbq.push_back(e);
    end
    f_req = 1; x_req = 1;
    nG = 0;
    for (int i = 1; i < 40 && nG < 4; i++) begin
      step();
      if (f_gnt || x_gnt) begin
        gntOwn[nG] = x_gnt;
        gntCyc[nG] = i;
        nG++;
        if (nG == 4) begin f_req = 0; x_req = 0; end
      end
    end
    check("tie_gnt_count", nG, 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("tie_order", {31'b0, gntOwn[k]}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k > 0) check("tie_spacing", gntCyc[k] - gntCyc[k-1], 32'd4);
    end
    drain();

    // Execute load with cycle-exact timing.
    e.owner = OWN_X; e.isWrite = 1'b0; e.data = 32'hDEAD_BEEF;
    sbq.push_back(e);
    x_req = 1; x_we = 0; x_addr = 32'h40;
    step();
    check("ld_gnt_c1", {30'b0, x_gnt, f_gnt}, 32'h2);
    check("ld_re_c1", {31'b0, mem_re}, 32'h1);
    check("ld_addr_c1", mem_addr, 32'h40);
    x_req = 0; x_addr = 32'hFFFF_FFF0;
    step();
    check("ld_c2", {29'b0, x_gnt, mem_re, busy}, 32'h3);
    check("ld_addr_c2", mem_addr, 32'h40);
    step();
    check("ld_done_c3", {30'b0, x_done, mem_re}, 32'h2);
    check("ld_rdata_c3", x_rdata, 32'hDEAD_BEEF);
    drain();

    // Store: one write strobe, x_rdata untouched.
    prevX = x_rdata;
    weCount = 0;
    runTxn(OWN_X, 1'b1, 32'h10, 32'h1234_5678);
    drain();
    check("st_we_count", weCount, 32'd1);
    check("st_addr", weAddr, 32'h10);
    check("st_data", weData, 32'h1234_5678);
    check("st_x_rdata", x_rdata, prevX);

    // Fetch pulsed while execute is busy must vanish.
    fGntCnt = 0;
    runTxn(OWN_X, 1'b0, 32'h80, 32'h0);
    f_req = 1; f_addr = 32'h300;
    step();
    f_req = 0;
    drain();
    step();
    check("drop_no_fgnt", fGntCnt, 32'd0);

    // Reset in the second ACCESS cycle aborts the fetch.
    f_req = 1; f_addr = 32'h300;
    step();
    check("abort_gnt", {31'b0, f_gnt}, 32'h1);
    f_req = 0;
    step();
    rst = 1'b1;
    #1;
    check("abort_ctl", {25'b0, busy, f_gnt, f_done, x_gnt, x_done, mem_we, mem_re}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_x_rdata", x_rdata, 32'h0);
    step();
    rst = 1'b0;
    step();
    step();
    runTxn(OWN_X, 1'b0, 32'hC0, 32'h0);
    drain();
    check("post_abort_f_rdata", f_rdata, 32'h0);

    // MEM_LAT=1 instance: one ACCESS cycle, done two cycles after the request.
    f1_req = 1; f1_addr = 32'h24;
    step();
    check("l1_gnt", {30'b0, f1_gnt, mem1_re}, 32'h3);
    check("l1_addr", mem1_addr, 32'h24);
    f1_req = 0; f1_addr = 32'h0;
    step();
    check("l1_done", {30'b0, f1_done, mem1_re}, 32'h2);
    check("l1_rdata", f1_rdata, memModel(32'h24));
    step();
    check("l1_idle", {30'b0, busy1, f1_done}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1);
  end

endmodule
